// File: rtl/qs_fifo_thresh_if.sv
// Producer/consumer bundle for qs_fifo_thresh.
// The FIFO takes the slave modport. The surrounding logic takes the master modport.
interface qs_fifo_thresh_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshake: push_i and pop_i are requests with no ready signal.
  // A push is taken when push_i & (!full_o | pop_i).
  // A pop is taken when pop_i & !empty_o.
  // A request that is not taken has no effect on the data.
  // It raises the matching sticky error flag.
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              err_clr_i;

  modport slave (
    input  push_i, push_data_i, pop_i, err_clr_i,
    output pop_data_o, count_o, full_o, empty_o, almost_full_o, almost_empty_o,
           overflow_o, underflow_o
  );

  modport master (
    output push_i, push_data_i, pop_i, err_clr_i,
    input  pop_data_o, count_o, full_o, empty_o, almost_full_o, almost_empty_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/qs_fifo_thresh.sv
// First-word fall-through FIFO of any depth, with a count and almost-full/almost-empty thresholds.
// Sticky overflow/underflow flags exist only when QS_FIFO_THRESH_ERR_EN is defined.
module qs_fifo_thresh #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 6,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  qs_fifo_thresh_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push_acc;
  logic              pop_acc;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // When the FIFO is full, a push is still taken if a pop frees a slot in the same cycle.
  assign push_acc = bus.push_i & (~full | bus.pop_i);
  assign pop_acc  = bus.pop_i & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= bus.push_data_i;
  end

  assign bus.pop_data_o     = mem[rd_ptr];
  assign bus.count_o        = count;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (count >= CNT_W'(AF_THRESH));
  assign bus.almost_empty_o = (count <= CNT_W'(AE_THRESH));

`ifdef QS_FIFO_THRESH_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.err_clr_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push_i & ~push_acc) overflow_q  <= 1'b1;
      if (bus.pop_i & ~pop_acc)   underflow_q <= 1'b1;
    end
  end

  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr  = bus.err_clr_i;
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_qs_fifo_thresh.sv
// Randomised and directed bench for qs_fifo_thresh.
// The reference model is a data queue plus two sticky error bits.
module tb_qs_fifo_thresh;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 6;
  localparam int AF_THRESH = 5;
  localparam int AE_THRESH = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  qs_fifo_thresh_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  qs_fifo_thresh #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  logic exp_ov;
  logic exp_un;
  int   n_vec;
  int   n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic ov_e;
    logic un_e;
    sz = exp_q.size();
`ifdef QS_FIFO_THRESH_ERR_EN
    ov_e = exp_ov;
    un_e = exp_un;
`else
    ov_e = 1'b0;
    un_e = 1'b0;
`endif
    check("count",        32'(bus.count_o),        32'(sz));
    check("full",         32'(bus.full_o),         32'(sz == DEPTH));
    check("empty",        32'(bus.empty_o),        32'(sz == 0));
    check("almost_full",  32'(bus.almost_full_o),  32'(sz >= AF_THRESH));
    check("almost_empty", 32'(bus.almost_empty_o), 32'(sz <= AE_THRESH));
    check("overflow",     32'(bus.overflow_o),     32'(ov_e));
    check("underflow",    32'(bus.underflow_o),    32'(un_e));
    if (sz > 0) check("pop_data", 32'(bus.pop_data_o), 32'(exp_q[0]));
  endtask

  // driver: one clock cycle from one negedge to the next, model updated on the edge
  task automatic step(input logic push, input logic [DATA_W-1:0] d, input logic pop,
                      input logic clr);
    bit m_full;
    bit m_empty;
    bit pa;
    bit qa;
    bus.push_i      = push;
    bus.push_data_i = d;
    bus.pop_i       = pop;
    bus.err_clr_i   = clr;
    m_full  = (exp_q.size() == DEPTH);
    m_empty = (exp_q.size() == 0);
    pa = push && (!m_full || pop);
    qa = pop && !m_empty;
    @(posedge clk);
    if (qa) void'(exp_q.pop_front());
    if (pa) exp_q.push_back(d);
    if (clr) begin
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end else begin
      if (push && !pa) exp_ov = 1'b1;
      if (pop && !qa)  exp_un = 1'b1;
    end
    @(negedge clk);
    bus.push_i    = 1'b0;
    bus.pop_i     = 1'b0;
    bus.err_clr_i = 1'b0;
    check_outputs();
  endtask

  task automatic push_one(input logic [DATA_W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ov = 1'b0;
    exp_un = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.push_i      = 1'b0;
    bus.push_data_i = '0;
    bus.pop_i       = 1'b0;
    bus.err_clr_i   = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // fill and wrap
    for (int i = 0; i < 6; i++) push_one(8'h10 + 8'(i));
    check("fill_full", 32'(bus.full_o), 32'd1);
    for (int i = 0; i < 3; i++) pop_one();
    for (int i = 0; i < 3; i++) push_one(8'h16 + 8'(i));
    for (int i = 0; i < 6; i++) pop_one();

    // full with simultaneous push and pop
    for (int i = 0; i < 6; i++) push_one(8'($urandom_range(0, 255)));
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) pop_one();

    // illegal push, illegal pop, then clear
    for (int i = 0; i < 6; i++) push_one(8'h40 + 8'(i));
    push_one(8'hBB);
    for (int i = 0; i < 6; i++) pop_one();
    pop_one();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // empty with simultaneous push and pop
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("empty_pp_data", 32'(bus.pop_data_o), 32'h33);
    step(1'b0, '0, 1'b0, 1'b1);
    pop_one();

    // asynchronous reset between edges
    for (int i = 0; i < 4; i++) push_one(8'($urandom_range(0, 255)));
    pop_one();
    pop_one();
    pop_one();
    pop_one();
    pop_one();
    for (int i = 0; i < 4; i++) push_one(8'($urandom_range(0, 255)));
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs();
    push_one(8'h01);
    check("post_reset_data", 32'(bus.pop_data_o), 32'h01);
    pop_one();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
